doctor_view_ctrl: RTL and testbench

- Consumes the doctor front-end's conditioned outputs: postop level, debounced change/history pulses and raw status level.
- Runs the display-mode state machine that selects which vital parameter is shown and whether the live value, a history sample or the alarm status page is shown.
- Tracks the history write pointer and produces the read address for the history sample memory.
- Sits between the doctor front-end and the display/history memory.

---
 rtl/doctor_pkg.sv | 14 +
 rtl/doctor_view_ctrl_rise_det.sv | 36 +++
 rtl/doctor_view_ctrl.sv | 126 ++++++++++++
 tb/tb_doctor_view_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/doctor_pkg.sv
// Shared display-mode encoding and default sizing for the doctor display path.
package doctor_pkg;

  localparam int NPARAM_DEF = 4;
  localparam int HDEPTH_DEF = 8;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_LIVE   = 2'd1,
    MODE_HIST   = 2'd2,
    MODE_STATUS = 2'd3
  } mode_e;

endpackage

// File: rtl/doctor_view_ctrl_rise_det.sv
// Button rising-edge detector; CONFIRM=2 needs two consecutive high samples.
// Latency: pulse is combinational on the sample that completes the rise; no backpressure.
module rise_det #(
  parameter int CONFIRM = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic level;
  logic prev;

  generate
    if (CONFIRM == 2) begin : g_confirm2
      logic s1;
      // Resets high so a button held through reset never produces a pulse.
      always_ff @(posedge clk) begin
        if (rst) s1 <= 1'b1;
        else     s1 <= din;
      end
      assign level = din & s1;
    end else begin : g_confirm1
      assign level = din;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b1;
    else     prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/doctor_view_ctrl.sv
// Display-mode FSM, parameter select and history addressing; STATUS auto-return under STATUS_TIMEOUT_EN.
// Latency: one clock from sampled button edge to registered outputs; no backpressure, every event acts at once.
module doctor_view_ctrl
  import doctor_pkg::*;
#(
  parameter int NPARAM  = NPARAM_DEF,
  parameter int PW      = 2,
  parameter int HDEPTH  = HDEPTH_DEF,
  parameter int HAW     = 3,
  parameter int TIMEOUT = 20,
  parameter int TW      = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           postop,
  input  logic           tasto_change,
  input  logic           tasto_hist,
  input  logic           tasto_status,
  input  logic           sample_valid,
  output logic [1:0]     disp_mode,
  output logic [PW-1:0]  sel_param,
  output logic [HAW-1:0] hist_idx,
  output logic [HAW-1:0] hist_addr,
  output logic [HAW-1:0] wr_ptr
);

  logic ev_change, ev_hist, ev_status;

  rise_det #(.CONFIRM(1)) u_det_change (.clk(clk), .rst(rst), .din(tasto_change), .pulse(ev_change));
  rise_det #(.CONFIRM(1)) u_det_hist   (.clk(clk), .rst(rst), .din(tasto_hist),   .pulse(ev_hist));
  rise_det #(.CONFIRM(2)) u_det_status (.clk(clk), .rst(rst), .din(tasto_status), .pulse(ev_status));

  mode_e          mode_q, mode_n;
  logic [PW-1:0]  sel_q, sel_n;
  logic [HAW-1:0] idx_q, idx_n;
  logic [HAW-1:0] wr_q, wr_n;
  logic [HAW-1:0] addr_q, addr_n;
`ifdef STATUS_TIMEOUT_EN
  logic [TW-1:0]  cnt_q, cnt_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_OFF;
      sel_q  <= '0;
      idx_q  <= '0;
      wr_q   <= '0;
      addr_q <= '1;
`ifdef STATUS_TIMEOUT_EN
      cnt_q  <= '0;
`endif
    end else begin
      mode_q <= mode_n;
      sel_q  <= sel_n;
      idx_q  <= idx_n;
      wr_q   <= wr_n;
      addr_q <= addr_n;
`ifdef STATUS_TIMEOUT_EN
      cnt_q  <= cnt_n;
`endif
    end
  end

  always_comb begin
    mode_n = mode_q;
    sel_n  = sel_q;
    idx_n  = idx_q;
`ifdef STATUS_TIMEOUT_EN
    cnt_n  = '0;
`endif
    wr_n   = wr_q + {{(HAW-1){1'b0}}, sample_valid};

    // Priority: postop low, then status, hist, change; only one acts per cycle.
    if (!postop) begin
      mode_n = MODE_OFF;
      idx_n  = '0;
    end else begin
      case (mode_q)
        MODE_OFF: mode_n = MODE_LIVE;
        MODE_LIVE: begin
          if (ev_status) begin
            mode_n = MODE_STATUS;
          end else if (ev_hist) begin
            mode_n = MODE_HIST;
            idx_n  = '0;
          end else if (ev_change) begin
            sel_n = (sel_q == PW'(NPARAM - 1)) ? '0 : sel_q + PW'(1);
          end
        end
        MODE_HIST: begin
          if (ev_status) begin
            mode_n = MODE_STATUS;
            idx_n  = '0;
          end else if (ev_hist) begin
            idx_n = (idx_q == HAW'(HDEPTH - 1)) ? '0 : idx_q + HAW'(1);
          end else if (ev_change) begin
            mode_n = MODE_LIVE;
            idx_n  = '0;
          end
        end
        MODE_STATUS: begin
`ifdef STATUS_TIMEOUT_EN
          cnt_n = cnt_q + TW'(1);
          if (ev_status || cnt_q == TW'(TIMEOUT - 1)) begin
            mode_n = MODE_LIVE;
            cnt_n  = '0;
          end
`else
          if (ev_status) mode_n = MODE_LIVE;
`endif
        end
        default: mode_n = MODE_OFF;
      endcase
    end

    // Uses next-state pointer and index so same-cycle updates are both reflected.
    addr_n = wr_n - HAW'(1) - idx_n;
  end

  assign disp_mode = mode_q;
  assign sel_param = sel_q;
  assign hist_idx  = idx_q;
  assign hist_addr = addr_q;
  assign wr_ptr    = wr_q;

endmodule

// File: tb/tb_doctor_view_ctrl.sv
// Scoreboarded directed bench for doctor_view_ctrl: expectations queued per cycle, checked on the falling edge.
module tb_doctor_view_ctrl;
  import doctor_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       postop = 1'b0, tasto_change = 1'b0, tasto_hist = 1'b0;
  logic       tasto_status = 1'b0, sample_valid = 1'b0;
  logic [1:0] disp_mode, sel_param;
  logic [2:0] hist_idx, hist_addr, wr_ptr;

  doctor_view_ctrl #(
    .NPARAM(4), .PW(2), .HDEPTH(8), .HAW(3), .TIMEOUT(20), .TW(8)
  ) dut (
    .clk(clk), .rst(rst), .postop(postop),
    .tasto_change(tasto_change), .tasto_hist(tasto_hist), .tasto_status(tasto_status),
    .sample_valid(sample_valid),
    .disp_mode(disp_mode), .sel_param(sel_param), .hist_idx(hist_idx),
    .hist_addr(hist_addr), .wr_ptr(wr_ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic [1:0] sel;
    logic [2:0] idx;
    logic [2:0] addr;
    logic [2:0] wr;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation due this cycle and compares against the outputs.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d was not checked in time (now %0d)", e.tag, e.cyc, cyc);
      end else if (disp_mode !== e.mode || sel_param !== e.sel || hist_idx !== e.idx ||
                   hist_addr !== e.addr || wr_ptr !== e.wr) begin
        errors++;
        $display("FAIL %s: got mode=%0d sel=%0d idx=%0d addr=%0d wr=%0d, want mode=%0d sel=%0d idx=%0d addr=%0d wr=%0d",
                 e.tag, disp_mode, sel_param, hist_idx, hist_addr, wr_ptr,
                 e.mode, e.sel, e.idx, e.addr, e.wr);
      end
    end
  end

  task automatic step(input logic po, input logic ch, input logic hi, input logic st, input logic sv);
    @(negedge clk);
    postop = po; tasto_change = ch; tasto_hist = hi; tasto_status = st; sample_valid = sv;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [1:0] m, input logic [1:0] s,
                           input logic [2:0] i, input logic [2:0] a, input logic [2:0] w);
    sb.push_back('{cyc, m, s, i, a, w, tag});
  endtask

  logic [1:0] sel_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [2:0] idx_seq [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  logic [2:0] adr_seq [8] = '{3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2};

  initial begin
    // Reset with change held high.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_st("reset", MODE_OFF, 2'd0, 3'd0, 3'd7, 3'd0);
    end
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_st("power_on_live", MODE_LIVE, 2'd0, 3'd0, 3'd7, 3'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_st("no_spurious_change", MODE_LIVE, 2'd0, 3'd0, 3'd7, 3'd0);

    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_st("change_seq", MODE_LIVE, sel_seq[i], 3'd0, 3'd7, 3'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_st("wr_ptr_1", MODE_LIVE, 2'd1, 3'd0, 3'd0, 3'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_st("wr_ptr_2", MODE_LIVE, 2'd1, 3'd0, 3'd1, 3'd2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_st("wr_ptr_3", MODE_LIVE, 2'd1, 3'd0, 3'd2, 3'd3);

    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_st("enter_hist", MODE_HIST, 2'd1, 3'd0, 3'd2, 3'd3);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_st("hist_browse", MODE_HIST, 2'd1, idx_seq[i], adr_seq[i], 3'd3);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_st("hist_change_to_live", MODE_LIVE, 2'd1, 3'd0, 3'd2, 3'd3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Status 1-cycle glitch must not act.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_st("glitch_edge", MODE_LIVE, 2'd1, 3'd0, 3'd2, 3'd3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_st("glitch_after", MODE_LIVE, 2'd1, 3'd0, 3'd2, 3'd3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Status confirms on its second high sample, coinciding with hist and change edges.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_st("status_unconfirmed", MODE_LIVE, 2'd1, 3'd0, 3'd2, 3'd3);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    expect_st("simultaneous_status", MODE_STATUS, 2'd1, 3'd0, 3'd2, 3'd3);
`ifdef STATUS_TIMEOUT_EN
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i < 20) expect_st("status_hold", MODE_STATUS, 2'd1, 3'd0, 3'd2, 3'd3);
      else        expect_st("status_timeout", MODE_LIVE, 2'd1, 3'd0, 3'd2, 3'd3);
    end
`else
    for (int i = 1; i <= 100; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i % 10 == 0) expect_st("status_no_timeout", MODE_STATUS, 2'd1, 3'd0, 3'd2, 3'd3);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_st("status_exit_wait", MODE_STATUS, 2'd1, 3'd0, 3'd2, 3'd3);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_st("status_exit", MODE_LIVE, 2'd1, 3'd0, 3'd2, 3'd3);
`endif
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Browse to idx 4, last step coinciding with a new sample.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_st("hist_again", MODE_HIST, 2'd1, 3'd0, 3'd2, 3'd3);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_st("hist_again_browse", MODE_HIST, 2'd1, idx_seq[i], adr_seq[i], 3'd3);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_st("hist_and_sample", MODE_HIST, 2'd1, 3'd4, 3'd7, 3'd4);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_st("postop_drop", MODE_OFF, 2'd1, 3'd0, 3'd3, 3'd4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    expect_st("sample_in_off", MODE_OFF, 2'd1, 3'd5 - 3'd5, 3'd4, 3'd5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_st("power_on_again", MODE_LIVE, 2'd1, 3'd0, 3'd4, 3'd5);

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
